// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divider constants and
// the baudrate select encoding (common to uart_rx and uart_tx).
package uart_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_e;

    // clk cycles per 16x sample tick at 50 MHz
    localparam int unsigned DIV_9600_50MHZ   = 326;
    localparam int unsigned DIV_115200_50MHZ = 27;

    // Baudrate select encoding
    localparam logic BAUD_9600   = 1'b0;
    localparam logic BAUD_115200 = 1'b1;

    // Tick counter width (enough for the slowest divider)
    localparam int unsigned TICK_CNT_W = 16;

    // Oversample counter landmarks: mid start bit and end of a full bit
    localparam logic [3:0] OS_MID  = 4'd7;
    localparam logic [3:0] OS_LAST = 4'd15;

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator. Emits a one-cycle tick every DIV clk
// cycles; 'clear' restarts the count so ticks are phase-aligned to an event.
module uart_baud_tick #(
    parameter int unsigned DIV0 = 326,
    parameter int unsigned DIV1 = 27,
    parameter int unsigned W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic div_sel,
    output logic tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] last_cnt;

    assign last_cnt = div_sel ? W'(DIV1 - 1) : W'(DIV0 - 1);
    assign tick     = (cnt_q == last_cnt);

    // Free-running divider, wraps after DIV cycles, restarted by clear
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, 16x oversampled. Produces a byte with a
// one-cycle done strobe, or a one-cycle frame_err strobe on a bad stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DIV_9600   = DIV_9600_50MHZ,
    parameter int unsigned DIV_115200 = DIV_115200_50MHZ,
    parameter bit          RX_INV     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        baudrate,
    input  logic        uart_rxd,
    output logic [7:0]  dout,
    output logic        done,
    output logic        frame_err,
    output logic        busy,
    output uart_state_e state_dbg
);

    logic [1:0]  sync_q;
    logic        s_rx;
    logic        tick;
    logic        start_det;
    uart_state_e state_q;
    logic [3:0]  os_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  dout_q;
    logic        done_q;
    logic        ferr_q;
    logic        busy_q;
    logic        baud_q;

    // 2-FF synchronizer; resets to line-idle so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rxd ^ RX_INV};
        end
    end

    assign s_rx      = sync_q[1];
    assign start_det = (state_q == ST_IDLE) && !s_rx;

    uart_baud_tick #(
        .DIV0 (DIV_9600),
        .DIV1 (DIV_115200),
        .W    (TICK_CNT_W)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_det),
        .div_sel (baud_q),
        .tick    (tick)
    );

    // Receive FSM with registered outputs; baud rate is latched at start detection
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            os_q    <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
            baud_q  <= BAUD_9600;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // busy drops one cycle after returning here, so it still
                    // covers the done cycle
                    busy_q <= !s_rx;
                    if (!s_rx) begin
                        state_q <= ST_START;
                        os_q    <= '0;
                        baud_q  <= baudrate;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (os_q == OS_MID) begin
                            os_q <= '0;
                            if (!s_rx) begin
                                state_q <= ST_DATA;
                                idx_q   <= '0;
                            end else begin
                                // start bit did not last to mid-bit: glitch
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            os_q <= os_q + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (os_q == OS_LAST) begin
                            os_q    <= '0;
                            shift_q <= {s_rx, shift_q[7:1]};
                            if (idx_q == 3'd7) begin
                                state_q <= ST_STOP;
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end else begin
                            os_q <= os_q + 4'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (os_q == OS_LAST) begin
                            os_q <= '0;
                            if (s_rx) begin
                                dout_q  <= shift_q;
                                done_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= ST_WAIT_HIGH;
                            end
                        end else begin
                            os_q <= os_q + 4'd1;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    // hold off until a held-low (break) line is released
                    if (s_rx) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dout      = dout_q;
    assign done      = done_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial driver, byte scoreboard, latency
// model and per-scenario tasks.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int D0 = 4;
  localparam int D1 = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        baudrate = 1'b0;
  logic        uart_rxd = 1'b1;
  logic [7:0]  dout;
  logic        done;
  logic        frame_err;
  logic        busy;
  uart_state_e state_dbg;

  uart_rx #(
    .DIV_9600   (D0),
    .DIV_115200 (D1),
    .RX_INV     (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baudrate  (baudrate),
    .uart_rxd  (uart_rxd),
    .dout      (dout),
    .done      (done),
    .frame_err (frame_err),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // scoreboard state
  logic [7:0] exp_q[$];
  int         done_cyc_q[$];
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         last_start = 0;
  int         last_div = D0;
  logic       prev_done = 1'b0;
  logic       busy_at_done = 1'b0;
  logic       busy_after_done = 1'b1;
  logic [7:0] exp_b;
  int         lat;
  int         exp_lat;

  // monitor: every done pulse is matched against the expected-byte queue
  // and its timing against the start-bit edge the driver produced
  always @(negedge clk) begin
    if (prev_done) busy_after_done = busy;
    prev_done = done;
    if (done) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
      busy_at_done = busy;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done dout=%h expected no done", dout);
      end else begin
        exp_b = exp_q.pop_front();
        if (dout !== exp_b) begin
          errors++;
          $display("FAIL done_byte dout=%h expected=%h", dout, exp_b);
        end
      end
      lat = cyc - last_start;
      exp_lat = 2 + (8 + 16 * 9) * last_div;
      checks++;
      if (lat < exp_lat - 2 || lat > exp_lat + 2) begin
        errors++;
        $display("FAIL done_latency got=%0d expected=%0d+-2", lat, exp_lat);
      end
      checks++;
      if (frame_err !== 1'b0) begin
        errors++;
        $display("FAIL done_with_frame_err frame_err=%b expected=0", frame_err);
      end
    end
    if (frame_err) ferr_cnt++;
  end

  // driver tasks (called at negedge)
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    last_start = cyc;
    last_div = div;
    for (int i = 0; i < 10; i++) begin
      uart_rxd = bits[i];
      repeat (16 * div) @(negedge clk);
    end
    uart_rxd = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    uart_rxd = 1'b1;
    baudrate = BAUD_9600;
    idle(3);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h expected=00", dout); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b expected=0", done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b expected=0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b expected=0", busy); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d expected=%0d", state_dbg, ST_IDLE); end
    rst = 1'b0;
    idle(5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b expected=0", busy); end
  endtask

  task automatic test_single_byte();
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b1, D0);
    idle(16 * D0);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single_done_count got=%0d expected=1", done_cnt - d0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL single_frame_err got=%0d expected=0", ferr_cnt - f0); end
    checks++; if (dout !== 8'h41) begin errors++; $display("FAIL single_dout got=%h expected=41", dout); end
    checks++; if (busy_at_done !== 1'b1) begin errors++; $display("FAIL single_busy_at_done got=%b expected=1", busy_at_done); end
    checks++; if (busy_after_done !== 1'b0) begin errors++; $display("FAIL single_busy_after_done got=%b expected=0", busy_after_done); end
  endtask

  task automatic test_framing_error();
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hC3, 1'b0, D0);
    uart_rxd = 1'b0;
    idle(3 * 16 * D0);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count got=%0d expected=1", ferr_cnt - f0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL ferr_done_count got=%0d expected=0", done_cnt - d0); end
    checks++; if (dout !== 8'h41) begin errors++; $display("FAIL ferr_dout_kept got=%h expected=41", dout); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low_line got=%b expected=1", busy); end
    checks++; if (state_dbg !== ST_WAIT_HIGH) begin errors++; $display("FAIL ferr_state got=%0d expected=%0d", state_dbg, ST_WAIT_HIGH); end
    uart_rxd = 1'b1;
    idle(8);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_released got=%b expected=0", busy); end
    d0 = done_cnt;
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, D0);
    idle(16 * D0);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ferr_next_done got=%0d expected=1", done_cnt - d0); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL ferr_next_dout got=%h expected=00", dout); end
  endtask

  task automatic test_glitch();
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    uart_rxd = 1'b0;
    idle(5 * D0);
    uart_rxd = 1'b1;
    idle(3 * D0 + 8);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got=%b expected=0", busy); end
    idle(32 * D0);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL glitch_done got=%0d expected=0", done_cnt - d0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_frame_err got=%0d expected=0", ferr_cnt - f0); end
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, D0);
    idle(16 * D0);
    checks++; if (dout !== 8'h7E) begin errors++; $display("FAIL glitch_next_dout got=%h expected=7e", dout); end
  endtask

  task automatic test_back_to_back();
    int n, gap;
    n = done_cyc_q.size();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send_frame(8'h55, 1'b1, D0);
    send_frame(8'hAA, 1'b1, D0);
    idle(16 * D0);
    checks++;
    if (done_cyc_q.size() - n !== 2) begin
      errors++;
      $display("FAIL b2b_done_count got=%0d expected=2", done_cyc_q.size() - n);
    end else begin
      gap = done_cyc_q[n + 1] - done_cyc_q[n];
      checks++;
      if (gap < 160 * D0 - 2 || gap > 160 * D0 + 2) begin
        errors++;
        $display("FAIL b2b_spacing got=%0d expected=%0d+-2", gap, 160 * D0);
      end
    end
    checks++; if (dout !== 8'hAA) begin errors++; $display("FAIL b2b_dout got=%h expected=aa", dout); end
  endtask

  task automatic test_baud_switch();
    int d0;
    d0 = done_cnt;
    baudrate = BAUD_115200;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, D1);
    idle(16 * D1);
    checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL baud_fast_dout got=%h expected=3c", dout); end
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1, D1);
      begin
        idle(40 * D1);
        baudrate = BAUD_9600;
      end
    join
    idle(16 * D1);
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL baud_done_count got=%0d expected=2", done_cnt - d0); end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL baud_toggle_dout got=%h expected=a5", dout); end
    idle(16 * D0);
  endtask

  task automatic test_reset_mid_frame();
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    baudrate = BAUD_9600;
    fork
      send_frame(8'hF0, 1'b1, D0);
      begin
        idle((5 * 16 + 8) * D0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b expected=0", busy); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL midrst_dout got=%h expected=00", dout); end
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL midrst_state got=%0d expected=%0d", state_dbg, ST_IDLE); end
      end
    join
    idle(16 * D0);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL midrst_done got=%0d expected=0", done_cnt - d0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL midrst_frame_err got=%0d expected=0", ferr_cnt - f0); end
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1, D0);
    idle(16 * D0);
    checks++; if (dout !== 8'h99) begin errors++; $display("FAIL midrst_next_dout got=%h expected=99", dout); end
  endtask

  task automatic test_random();
    int d0, f0, div;
    logic [7:0] b;
    logic sel;
    d0 = done_cnt; f0 = ferr_cnt;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
      sel = 1'($urandom_range(0, 1));
      baudrate = sel;
      div = sel ? D1 : D0;
      exp_q.push_back(b);
      send_frame(b, 1'b1, div);
      idle($urandom_range(0, 20));
    end
    idle(16 * D0);
    checks++; if (done_cnt - d0 !== 24) begin errors++; $display("FAIL rand_done_count got=%0d expected=24", done_cnt - d0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL rand_frame_err got=%0d expected=0", ferr_cnt - f0); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_framing_error();
    test_glitch();
    test_back_to_back();
    test_baud_switch();
    test_reset_mid_frame();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
